// File: rtl/polyvec_collector_pkg.sv
// ---------------------------------------------------------------------------
// TYPES_KEM: shared ML-KEM types and constants.
// Holds the module rank, polynomial length and modulus, the packed
// polynomial type and the collector FSM state type. The collector state type
// lives here so the keygen/encap FSMs can inspect it.
// ---------------------------------------------------------------------------
package TYPES_KEM;

   localparam int ML_KEM_K = 3;
   localparam int ML_KEM_N = 256;
   localparam int ML_KEM_Q = 3329;

   typedef logic [ML_KEM_N-1:0][11:0] poly_t;

   typedef enum logic [1:0] {
      CS_IDLE    = 2'd0,
      CS_COLLECT = 2'd1,
      CS_DONE    = 2'd2
   } collect_state_t;

endpackage

// File: rtl/polyvec_collector_if.sv
// ---------------------------------------------------------------------------
// polyvec_collector_if: control, coefficient stream and result bus of the
// polynomial-vector collector.
//   master : drives run_i, n_poly_i, vld_i, din_i; observes status + vector
//   slave  : the collector itself
//   run_i      start pulse (sampled in IDLE only)
//   n_poly_i   number of polynomials to collect, 1..N_POLY
//   vld_i      din_i valid this cycle
//   din_i      coefficient
//   busy_o     collection in progress
//   done_o     one-cycle pulse after the last coefficient is stored
//   err_o      sticky: some accepted coefficient was >= Q
//   poly_idx_o polynomial currently being filled
//   polyvec_o  collected polynomials, polyvec_o[p][c]
// ---------------------------------------------------------------------------
interface polyvec_collector_if #(
   parameter int N_POLY = 2 * TYPES_KEM::ML_KEM_K,
   parameter int N      = TYPES_KEM::ML_KEM_N,
   parameter int COEF_W = 12
) ();

   logic                                 run_i;
   logic [2:0]                           n_poly_i;
   logic                                 vld_i;
   logic [COEF_W-1:0]                    din_i;
   logic                                 busy_o;
   logic                                 done_o;
   logic                                 err_o;
   logic [2:0]                           poly_idx_o;
   logic [N_POLY-1:0][N-1:0][COEF_W-1:0] polyvec_o;

   modport master (
      output run_i, n_poly_i, vld_i, din_i,
      input  busy_o, done_o, err_o, poly_idx_o, polyvec_o
   );

   modport slave (
      input  run_i, n_poly_i, vld_i, din_i,
      output busy_o, done_o, err_o, poly_idx_o, polyvec_o
   );

endinterface

// File: rtl/polyvec_collector_coef_addr_counter.sv
// ---------------------------------------------------------------------------
// coef_addr_counter: coefficient counter cascaded into a polynomial counter.
//   clk_i, rst_i  clock, synchronous active-high reset
//   clr_i         clear both counters (start of a collection)
//   en_i          advance by one coefficient
//   last_poly_i   index of the final polynomial of this collection
//   coef_cnt_o    coefficient index within the current polynomial
//   poly_cnt_o    current polynomial index
//   tc_o          terminal count: current slot is the final coefficient
// ---------------------------------------------------------------------------
module coef_addr_counter #(
   parameter  int N     = 256,
   localparam int CNT_W = $clog2(N)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [2:0]       last_poly_i,
   output logic [CNT_W-1:0] coef_cnt_o,
   output logic [2:0]       poly_cnt_o,
   output logic             tc_o
);

   logic [CNT_W-1:0] coef_cnt_reg;
   logic [2:0]       poly_cnt_reg;
   logic             coef_wrap;

   assign coef_wrap = (coef_cnt_reg == CNT_W'(N - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         coef_cnt_reg <= '0;
         poly_cnt_reg <= '0;
      end else if (en_i) begin
         coef_cnt_reg <= coef_wrap ? '0 : coef_cnt_reg + 1'b1;
         // The polynomial counter also steps on the final wrap, so after a
         // complete collection it reads the requested polynomial count.
         if (coef_wrap)
            poly_cnt_reg <= poly_cnt_reg + 3'd1;
      end
   end

   assign coef_cnt_o = coef_cnt_reg;
   assign poly_cnt_o = poly_cnt_reg;
   assign tc_o       = coef_wrap && (poly_cnt_reg == last_poly_i);

endmodule

// File: rtl/polyvec_collector.sv
// ---------------------------------------------------------------------------
// polyvec_collector: reassembles the serial NTT output stream (one
// coefficient per valid cycle) into a packed vector of polynomials.
//   clk_i   clock
//   rst_i   synchronous active-high reset; clears state, flags and vector
//   bus     polyvec_collector_if.slave (run/n_poly/vld/din in;
//           busy/done/err/poly_idx/polyvec out)
// FSM: IDLE -> COLLECT on a valid run, COLLECT -> DONE on the final accepted
// coefficient, DONE -> IDLE after one cycle.
// ---------------------------------------------------------------------------
module polyvec_collector
   import TYPES_KEM::*;
#(
   parameter int K      = ML_KEM_K,
   parameter int N_POLY = 2 * K,
   parameter int N      = ML_KEM_N,
   parameter int COEF_W = 12,
   parameter int Q      = ML_KEM_Q
) (
   input  logic                clk_i,
   input  logic                rst_i,
   polyvec_collector_if.slave  bus
);

   localparam int CW = $clog2(N);

   collect_state_t state_reg, state_next;
   logic [2:0]     n_poly_reg;
   logic           err_reg;
   logic           start;
   logic           accept;
   logic           n_ok;
   logic [CW-1:0]  coef_cnt;
   logic [2:0]     poly_cnt;
   logic           tc;

   // Widened by one bit so an N_POLY of 8 still compares correctly.
   assign n_ok = (bus.n_poly_i != 3'd0) && ({1'b0, bus.n_poly_i} <= 4'(N_POLY));

   always_comb begin
      state_next = state_reg;
      start      = 1'b0;
      accept     = 1'b0;
      case (state_reg)
         CS_IDLE: begin
            if (bus.run_i && n_ok) begin
               start      = 1'b1;
               state_next = CS_COLLECT;
            end
         end
         CS_COLLECT: begin
            accept = bus.vld_i;
            if (bus.vld_i && tc)
               state_next = CS_DONE;
         end
         CS_DONE:  state_next = CS_IDLE;
         default:  state_next = CS_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg  <= CS_IDLE;
         n_poly_reg <= '0;
         err_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (start) begin
            n_poly_reg <= bus.n_poly_i;
            err_reg    <= 1'b0;
         end else if (accept && (bus.din_i >= COEF_W'(Q))) begin
            err_reg <= 1'b1;
         end
      end
   end

   coef_addr_counter #(.N(N)) u_cnt (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clr_i       (start),
      .en_i        (accept),
      .last_poly_i (n_poly_reg - 3'd1),
      .coef_cnt_o  (coef_cnt),
      .poly_cnt_o  (poly_cnt),
      .tc_o        (tc)
   );

   // One register row per polynomial; every row must be visible at once and
   // cleared by reset, so the storage is flops rather than a RAM.
   generate
      for (genvar gi = 0; gi < N_POLY; gi++) begin : g_poly
         logic [N-1:0][COEF_W-1:0] row_reg;

         always_ff @(posedge clk_i) begin
            if (rst_i)
               row_reg <= '0;
            else if (accept && (poly_cnt == 3'(gi)))
               row_reg[coef_cnt] <= bus.din_i;
         end

         assign bus.polyvec_o[gi] = row_reg;
      end
   endgenerate

   assign bus.busy_o     = (state_reg == CS_COLLECT);
   assign bus.done_o     = (state_reg == CS_DONE);
   assign bus.err_o      = err_reg;
   assign bus.poly_idx_o = poly_cnt;

endmodule

// File: tb/tb_polyvec_collector.sv
module tb_polyvec_collector;
   import TYPES_KEM::*;

   localparam int NP = 6;
   localparam int NC = 256;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   polyvec_collector_if #(.N_POLY(NP)) bus ();

   polyvec_collector #(.K(3)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference: coefficient number k of a collection lands at
   // polynomial k/256, position k%256; the error flag is "any stored >= Q".
   logic [11:0] model [NP][NC];
   logic        model_err;

   typedef struct {
      logic [2:0] n;
      logic       run;
      logic       exp_busy;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_model();
      for (int p = 0; p < NP; p++)
         for (int c = 0; c < NC; c++)
            model[p][c] = 12'h000;
      model_err = 1'b0;
   endtask

   task automatic compare_all(input string name);
      int nerr;
      nerr = 0;
      for (int p = 0; p < NP; p++)
         for (int c = 0; c < NC; c++)
            if (bus.polyvec_o[p][c] !== model[p][c]) begin
               if (nerr == 0)
                  $display("  %s first diff p=%0d c=%0d got %0h want %0h",
                           name, p, c, bus.polyvec_o[p][c], model[p][c]);
               nerr++;
            end
      check(name, nerr, 0);
   endtask

   task automatic do_reset();
      bus.run_i = 1'b0;
      bus.vld_i = 1'b0;
      rst_i     = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
      clear_model();
   endtask

   // gap_mode: 0 back-to-back, 1 vld pattern 1-0-0-1, 2 random
   // data_mode: 0 (k+off) mod Q, 1 random 12-bit
   task automatic collect(input int n, input int gap_mode, input int data_mode, input int off,
                          input int inj_k, input logic [11:0] inj_val, input int run_k);
      int k, cyc, total_k;
      int e_done, e_busy, e_idx, e_err, e_wr;
      logic v;
      logic [11:0] d;
      k = 0; cyc = 0; total_k = n * NC;
      e_done = 0; e_busy = 0; e_idx = 0; e_err = 0; e_wr = 0;

      bus.n_poly_i = 3'(n);
      bus.run_i    = 1'b1;
      tick();
      bus.run_i = 1'b0;
      model_err = 1'b0;
      check("start_busy", 32'(bus.busy_o), 1);
      check("start_err_clear", 32'(bus.err_o), 0);

      while (k < total_k) begin
         case (gap_mode)
            0:       v = 1'b1;
            1:       v = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: v = 1'($urandom_range(0, 1));
         endcase
         d = (data_mode == 0) ? 12'((k + off) % 3329) : 12'($urandom_range(0, 4095));
         if (k == inj_k) d = inj_val;
         bus.vld_i    = v;
         bus.din_i    = v ? d : 12'hABC;
         bus.run_i    = (k == run_k);
         bus.n_poly_i = (k == run_k) ? 3'd1 : 3'(n);
         tick();
         cyc++;
         if (v) begin
            model[k / NC][k % NC] = d;
            if (d >= 12'd3329) model_err = 1'b1;
            if (bus.polyvec_o[k / NC][k % NC] !== d) e_wr++;
            k++;
         end
         if (k < total_k) begin
            if (bus.done_o)                      e_done++;
            if (!bus.busy_o)                     e_busy++;
            if (bus.poly_idx_o != 3'(k / NC))    e_idx++;
         end
         if (bus.err_o !== model_err) e_err++;
         if (cyc > 40000) begin
            total++;
            bad++;
            $display("FAIL collect_timeout: got %0d accepts want %0d", k, total_k);
            break;
         end
      end
      bus.run_i    = 1'b0;
      bus.n_poly_i = 3'(n);

      check("early_done", e_done, 0);
      check("busy_during_collect", e_busy, 0);
      check("poly_idx_track", e_idx, 0);
      check("err_track", e_err, 0);
      check("write_latency", e_wr, 0);
      check("done_pulse", 32'(bus.done_o), 1);
      check("busy_in_done", 32'(bus.busy_o), 0);
      check("poly_idx_final", 32'(bus.poly_idx_o), 32'(n & 7));

      // vld with junk in DONE then IDLE must be ignored.
      bus.vld_i = 1'b1;
      bus.din_i = 12'hABC;
      tick();
      check("done_single", 32'(bus.done_o), 0);
      check("idle_busy", 32'(bus.busy_o), 0);
      tick();
      check("idle_poly_idx", 32'(bus.poly_idx_o), 32'(n & 7));
      check("idle_err", 32'(bus.err_o), 32'(model_err));
      bus.vld_i = 1'b0;
      compare_all("polyvec_contents");
      $display("collect n=%0d gaps=%0d data=%0d cycles=%0d err=%0b",
               n, gap_mode, data_mode, cyc, model_err);
   endtask

   initial begin
      vec_t tbl[6];
      tbl[0] = '{n: 3'd0, run: 1'b1, exp_busy: 1'b0};
      tbl[1] = '{n: 3'd7, run: 1'b1, exp_busy: 1'b0};
      tbl[2] = '{n: 3'd3, run: 1'b0, exp_busy: 1'b0};
      tbl[3] = '{n: 3'd1, run: 1'b1, exp_busy: 1'b1};
      tbl[4] = '{n: 3'd6, run: 1'b1, exp_busy: 1'b1};
      tbl[5] = '{n: 3'd4, run: 1'b1, exp_busy: 1'b1};

      bus.run_i    = 1'b0;
      bus.n_poly_i = 3'd0;
      bus.vld_i    = 1'b0;
      bus.din_i    = 12'h000;

      // Reset state
      do_reset();
      check("rst_busy", 32'(bus.busy_o), 0);
      check("rst_done", 32'(bus.done_o), 0);
      check("rst_err", 32'(bus.err_o), 0);
      check("rst_poly_idx", 32'(bus.poly_idx_o), 0);
      compare_all("rst_polyvec");

      // Start acceptance table; vld with 0xABC alongside run is not stored.
      for (int i = 0; i < 6; i++) begin
         do_reset();
         bus.n_poly_i = tbl[i].n;
         bus.run_i    = tbl[i].run;
         bus.vld_i    = 1'b1;
         bus.din_i    = 12'hABC;
         tick();
         bus.run_i = 1'b0;
         bus.vld_i = 1'b0;
         check($sformatf("tbl%0d_busy", i), 32'(bus.busy_o), 32'(tbl[i].exp_busy));
         check($sformatf("tbl%0d_poly_idx", i), 32'(bus.poly_idx_o), 0);
         check($sformatf("tbl%0d_no_write", i), 32'(bus.polyvec_o[0][0]), 0);
         tick();
         check($sformatf("tbl%0d_busy_hold", i), 32'(bus.busy_o), 32'(tbl[i].exp_busy));
         $display("table n=%0d run=%0b busy=%0b", tbl[i].n, tbl[i].run, bus.busy_o);
      end
      do_reset();

      // Full K=3 vector, back-to-back, (p*256+c) mod Q
      collect(6, 0, 0, 0, -1, 12'h000, -1);
      // Two polynomials with vld 1-0-0-1; polys 2..5 must keep prior data
      collect(2, 1, 0, 1000, -1, 12'h000, -1);
      // Out-of-range coefficient at p=1, c=17
      collect(2, 0, 0, 7, 256 + 17, 12'hD01, -1);
      check("inject_stored", 32'(bus.polyvec_o[1][17]), 32'h0D01);
      // run during COLLECT at coefficient 100 is ignored; also clears err
      collect(6, 0, 0, 3, -1, 12'h000, 100);

      // Reset after 300 coefficients
      bus.n_poly_i = 3'd6;
      bus.run_i    = 1'b1;
      tick();
      bus.run_i = 1'b0;
      for (int i = 0; i < 300; i++) begin
         bus.vld_i = 1'b1;
         bus.din_i = (i == 0) ? 12'd4000 : 12'($urandom_range(0, 3328));
         tick();
      end
      bus.vld_i = 1'b0;
      check("pre_rst_err", 32'(bus.err_o), 1);
      rst_i = 1'b1;
      tick();
      clear_model();
      check("midrst_busy", 32'(bus.busy_o), 0);
      check("midrst_done", 32'(bus.done_o), 0);
      check("midrst_err", 32'(bus.err_o), 0);
      check("midrst_poly_idx", 32'(bus.poly_idx_o), 0);
      compare_all("midrst_polyvec");
      rst_i = 1'b0;
      tick();
      $display("reset after 300 coefficients");
      collect(1, 0, 0, 5, -1, 12'h000, -1);

      // Randomized collections
      for (int r = 0; r < 3; r++)
         collect($urandom_range(1, 6), 2, 1, 0, -1, 12'h000, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
